// File: rtl/dk_sound_pkg.sv
// Shared types and sizing helpers for the sound gate sequencer.
// No logic; hold-counter width and accumulator sizing live here so the top and channels agree.
package dk_sound_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } gate_state_t;

  localparam int CNT_W = 16;

  // Accumulator must hold acc + SAMPLE_RATE, which stays below 2*CLOCK_RATE.
  function automatic int acc_width(input int clock_rate);
    return $clog2(clock_rate) + 1;
  endfunction

endpackage

// File: rtl/sound_gate_channel.sv
// One trigger channel: edge detect, IDLE/ACTIVE/HOLD FSM and sample-tick hold counter.
// Gate is registered, 1 cycle after the rising trigger is sampled; no backpressure, mute overrides all.
module sound_gate_channel
  import dk_sound_pkg::*;
#(
  parameter int MIN_HOLD = 2400,
  parameter bit ONESHOT  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic tick,
  input  logic mute,
  output logic gate,
  output logic gate_nxt
);

  localparam logic [CNT_W-1:0] HOLD_LEN = CNT_W'(MIN_HOLD);

  gate_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_dec;
  logic             trig_q, rise;

  assign rise    = trig & ~trig_q;
  assign cnt_dec = (cnt != '0) ? cnt - 1'b1 : '0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (mute) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (rise && (ONESHOT || state != ACTIVE)) begin
      // A reload always beats a coincident tick.
      state_n = ACTIVE;
      cnt_n   = HOLD_LEN;
    end else if (ONESHOT) begin
      if (state != IDLE && tick) begin
        cnt_n = cnt_dec;
        if (cnt_dec == '0) state_n = IDLE;
      end
    end else begin
      case (state)
        ACTIVE: begin
          if (tick) cnt_n = cnt_dec;
          if (!trig) state_n = (cnt_n != '0) ? HOLD : IDLE;
        end
        HOLD: begin
          if (tick) begin
            cnt_n = cnt_dec;
            if (cnt_dec == '0) state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign gate_nxt = (state_n != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      trig_q <= 1'b0;
      gate   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      trig_q <= trig;
      gate   <= gate_nxt;
    end
  end

endmodule

// File: rtl/dk_sound_gate_ctrl.sv
// Sound-latch sequencer: fractional audio sample strobe plus NUM_CH min-hold gate channels.
// Gates follow trigger rises after 1 cycle; first strobe after ceil(CLOCK_RATE/SAMPLE_RATE) edges; no backpressure.
module dk_sound_gate_ctrl
  import dk_sound_pkg::*;
#(
  parameter int                CLOCK_RATE   = 1000000,
  parameter int                SAMPLE_RATE  = 48000,
  parameter int                NUM_CH       = 4,
  parameter int                MIN_HOLD     = 2400,
  parameter logic [NUM_CH-1:0] ONESHOT_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig,
  input  logic              mute,
  output logic              audio_clk_en,
  output logic [NUM_CH-1:0] gate,
  output logic              active
);

  localparam int               ACC_W = acc_width(CLOCK_RATE);
  localparam logic [ACC_W-1:0] SR    = ACC_W'(SAMPLE_RATE);
  localparam logic [ACC_W-1:0] CR    = ACC_W'(CLOCK_RATE);

  logic [ACC_W-1:0]  acc, acc_sum;
  logic [NUM_CH-1:0] gate_nxt;

  assign acc_sum = acc + SR;

  // Phase accumulator: strobe count is exact over any CLOCK_RATE-cycle window.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      audio_clk_en <= 1'b0;
    end else if (acc_sum >= CR) begin
      acc          <= acc_sum - CR;
      audio_clk_en <= 1'b1;
    end else begin
      acc          <= acc_sum;
      audio_clk_en <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sound_gate_channel #(
      .MIN_HOLD (MIN_HOLD),
      .ONESHOT  (ONESHOT_MASK[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .trig     (trig[i]),
      .tick     (audio_clk_en),
      .mute     (mute),
      .gate     (gate[i]),
      .gate_nxt (gate_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) active <= 1'b0;
    else       active <= |gate_nxt;
  end

endmodule

// File: tb/tb_dk_sound_gate_ctrl.sv
// Directed bench for dk_sound_gate_ctrl with MIN_HOLD=4, channel 0 one-shot, channels 1-3 level mode.
module tb_dk_sound_gate_ctrl;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       mute  = 1'b0;
  logic [3:0] trig  = 4'b0000;
  logic       audio_clk_en;
  logic       active;
  logic [3:0] gate;

  int checks   = 0;
  int failures = 0;
  int ticks    = 0;

  always #5 clk = ~clk;

  dk_sound_gate_ctrl #(
    .CLOCK_RATE   (1000000),
    .SAMPLE_RATE  (48000),
    .NUM_CH       (4),
    .MIN_HOLD     (4),
    .ONESHOT_MASK (4'b0001)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .trig         (trig),
    .mute         (mute),
    .audio_clk_en (audio_clk_en),
    .gate         (gate),
    .active       (active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; count the strobe the edge consumed as a tick.
  task automatic step();
    logic en_prev;
    en_prev = audio_clk_en;
    @(posedge clk);
    #1;
    if (en_prev) ticks++;
  endtask

  task automatic wait_fall(input int ch, input string tag);
    int n;
    n = 0;
    while (gate[ch] && n < 300) begin
      step();
      n++;
    end
    check({tag, "_fell"}, 32'(gate[ch]), 0);
    check({tag, "_ticks"}, ticks, 4);
  endtask

  initial begin
    int n;
    int first;
    int last;
    int cnt;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst_gate", gate, 0);
    check("rst_active", active, 0);
    check("rst_strobe", audio_clk_en, 0);

    // Strobe rate over the first 1000 edges after release
    reset = 1'b0;
    first = 0; last = 0; cnt = 0;
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (audio_clk_en) begin
        if (cnt == 0) first = e;
        else check("strobe_gap", 32'(((e - last) == 20) || ((e - last) == 21)), 1);
        last = e;
        cnt++;
      end
    end
    check("first_strobe", first, 21);
    check("strobes_1000", cnt, 48);
    check("idle_gate", gate, 0);

    // One-shot pulse
    trig[0] = 1'b1;
    step();
    check("os_gate_on", 32'(gate[0]), 1);
    check("os_active", active, 1);
    ticks = 0;
    trig[0] = 1'b0;
    wait_fall(0, "os");
    check("os_active_off", active, 0);

    // One-shot retrigger mid-gate
    trig[0] = 1'b1;
    step();
    ticks = 0;
    trig[0] = 1'b0;
    n = 0;
    while (ticks < 2 && n < 200) begin
      step();
      n++;
    end
    check("rt_mid_gate", 32'(gate[0]), 1);
    trig[0] = 1'b1;
    step();
    check("rt_cnt", dut.g_ch[0].u_ch.cnt, 4);
    ticks = 0;
    trig[0] = 1'b0;
    wait_fall(0, "rt");

    // Rise coincident with a strobe
    n = 0;
    while (!audio_clk_en && n < 50) begin
      step();
      n++;
    end
    check("sim_strobe_seen", audio_clk_en, 1);
    trig[0] = 1'b1;
    step();
    check("sim_cnt", dut.g_ch[0].u_ch.cnt, 4);
    ticks = 0;
    trig[0] = 1'b0;
    wait_fall(0, "sim");

    // Level mode, short trigger: minimum hold dominates
    trig[1] = 1'b1;
    step();
    ticks = 0;
    check("lv10_on", 32'(gate[1]), 1);
    repeat (9) step();
    trig[1] = 1'b0;
    wait_fall(1, "lv10");

    // Level mode, long trigger: gate follows trig
    trig[1] = 1'b1;
    repeat (500) step();
    check("lv500_high", 32'(gate[1]), 1);
    check("lv500_active", active, 1);
    trig[1] = 1'b0;
    step();
    check("lv500_fall", 32'(gate[1]), 0);
    check("lv500_active_off", active, 0);

    // Mute during HOLD and ACTIVE
    trig[2] = 1'b1;
    step();
    trig[2] = 1'b0;
    step();
    trig[3] = 1'b1;
    step();
    check("mute_pre", gate, 4'b1100);
    mute = 1'b1;
    step();
    check("mute_gate", gate, 0);
    check("mute_active", active, 0);
    trig[2] = 1'b1;
    step();
    trig[2] = 1'b0;
    check("mute_rise_ignored", gate, 0);
    mute = 1'b0;
    repeat (5) step();
    check("unmute_no_restart", gate, 0);
    trig[3] = 1'b0;
    step();
    trig[3] = 1'b1;
    step();
    check("unmute_retrig", gate, 4'b1000);
    check("unmute_active", active, 1);

    // Reset mid-operation with three gates open
    trig[1] = 1'b1;
    trig[0] = 1'b1;
    step();
    trig[0] = 1'b0;
    step();
    check("pre_reset_gate", gate, 4'b1011);
    reset = 1'b1;
    step();
    check("mid_rst_gate", gate, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_strobe", audio_clk_en, 0);
    reset = 1'b0;
    step();
    check("post_rst_rise", gate, 4'b1010);
    n = 1;
    while (!audio_clk_en && n < 40) begin
      step();
      n++;
    end
    check("post_rst_strobe", n, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
